// File: rtl/microondas_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | microondas_pkg: shared constants and state encoding for time entry    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package microondas_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [DIGIT_W-1:0] KEY_LAST_DIGIT = 4'd9;
  localparam logic [DIGIT_W-1:0] KEY_START      = 4'd10;
  localparam logic [DIGIT_W-1:0] KEY_CANCEL     = 4'd11;
  localparam logic [DIGIT_W-1:0] BCD_ZERO       = 4'd0;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_SEND  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_digit_key(input logic [DIGIT_W-1:0] code);
    return code <= KEY_LAST_DIGIT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/microondas_entry_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | microondas_entry_buffer: BCD digit shift register with indexed read   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module microondas_entry_buffer #(
  parameter int NUM_DIGITS = 3,
  parameter int DIGIT_W    = 4,
  parameter int IDX_W      = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          shift_i,
  input  logic                          clear_i,
  input  logic [DIGIT_W-1:0]            digit_i,
  input  logic [IDX_W-1:0]              rd_idx_i,
  output logic [DIGIT_W-1:0]            rd_data_o,
  output logic                          is_zero_o,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_o
);

  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_d;

  // Clear and shift together leave only the new digit in the units slot.
  always_comb begin
    digits_d = digits_q;
    if (clear_i && shift_i) begin
      digits_d = {{((NUM_DIGITS - 1) * DIGIT_W){1'b0}}, digit_i};
    end else if (clear_i) begin
      digits_d = '0;
    end else if (shift_i) begin
      digits_d = {digits_q[(NUM_DIGITS-1)*DIGIT_W-1:0], digit_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rd_idx_i == i[IDX_W-1:0]) begin
        rd_data_o = digits_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign is_zero_o = (digits_q == '0);
  assign digits_o  = digits_q;

endmodule
`default_nettype wire

// File: rtl/microondas_time_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | microondas_time_entry: keypad time entry, serial load of the timer    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module microondas_time_entry
  import microondas_pkg::*;
(
  input  logic               clock,
  input  logic               Cn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               zero,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               count_en,
  output logic               timer_clr_n,
  output logic [DIGIT_W-1:0] entry_min,
  output logic [DIGIT_W-1:0] entry_sec_t,
  output logic [DIGIT_W-1:0] entry_sec_u,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               first_run_q, first_run_d;
  logic [DIGIT_W-1:0] digit_out_q, digit_out_d;
  logic               count_en_q, count_en_d;
  logic               timer_clr_n_q, timer_clr_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic                          buf_shift;
  logic                          buf_clear;
  logic                          buf_is_zero;
  logic [IDX_W-1:0]              buf_rd_idx;
  logic [DIGIT_W-1:0]            buf_rd_data;
  logic [NUM_DIGITS*DIGIT_W-1:0] buf_digits;

  logic key_digit;
  logic key_start;
  logic key_cancel;
  logic key_any;

  assign key_digit  = key_valid && is_digit_key(key_code);
  assign key_start  = key_valid && (key_code == KEY_START);
  assign key_cancel = key_valid && (key_code == KEY_CANCEL);
  assign key_any    = key_valid && (key_code <= KEY_CANCEL);

  // Read one digit ahead: idx_q names the digit already on digit_out.
  assign buf_rd_idx = (state_q == ST_ENTRY) ? IDX_LAST : (idx_q - IDX_ONE);

  microondas_entry_buffer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .IDX_W      (IDX_W)
  ) u_entry_buffer (
    .clk_i     (clock),
    .rst_ni    (Cn),
    .shift_i   (buf_shift),
    .clear_i   (buf_clear),
    .digit_i   (key_code),
    .rd_idx_i  (buf_rd_idx),
    .rd_data_o (buf_rd_data),
    .is_zero_o (buf_is_zero),
    .digits_o  (buf_digits)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    first_run_d   = 1'b0;
    digit_out_d   = digit_out_q;
    timer_clr_n_d = 1'b1;
    buf_shift     = 1'b0;
    buf_clear     = 1'b0;

    unique case (state_q)
      ST_ENTRY: begin
        if (key_cancel) begin
          buf_clear = 1'b1;
        end else if (key_digit) begin
          buf_shift = 1'b1;
        end else if (key_start && !buf_is_zero) begin
          state_d     = ST_SEND;
          idx_d       = IDX_LAST;
          digit_out_d = buf_rd_data;
        end
      end

      ST_SEND: begin
        if (key_cancel) begin
          state_d       = ST_ENTRY;
          idx_d         = IDX_ZERO;
          timer_clr_n_d = 1'b0;
          buf_clear     = 1'b1;
        end else if (idx_q == IDX_ZERO) begin
          state_d     = ST_RUN;
          first_run_d = 1'b1;
        end else begin
          idx_d       = idx_q - IDX_ONE;
          digit_out_d = buf_rd_data;
        end
      end

      ST_RUN: begin
        // The timer's zero flag is stale on the first counting cycle.
        if (key_cancel) begin
          state_d       = ST_ENTRY;
          timer_clr_n_d = 1'b0;
          buf_clear     = 1'b1;
        end else if (!first_run_q && zero) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (key_any) begin
          state_d   = ST_ENTRY;
          buf_clear = 1'b1;
          buf_shift = key_digit;
        end
      end

      default: begin
        state_d = ST_ENTRY;
      end
    endcase

    count_en_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_SEND) || (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge Cn) begin
    if (!Cn) begin
      state_q       <= ST_ENTRY;
      idx_q         <= IDX_ZERO;
      first_run_q   <= 1'b0;
      digit_out_q   <= BCD_ZERO;
      count_en_q    <= 1'b0;
      timer_clr_n_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      first_run_q   <= first_run_d;
      digit_out_q   <= digit_out_d;
      count_en_q    <= count_en_d;
      timer_clr_n_q <= timer_clr_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign digit_out   = digit_out_q;
  assign count_en    = count_en_q;
  assign timer_clr_n = timer_clr_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign entry_min   = buf_digits[2*DIGIT_W +: DIGIT_W];
  assign entry_sec_t = buf_digits[1*DIGIT_W +: DIGIT_W];
  assign entry_sec_u = buf_digits[0 +: DIGIT_W];

endmodule
`default_nettype wire

// File: tb/tb_microondas_time_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_microondas_time_entry: scoreboard bench with reference model+timer |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_microondas_time_entry;

  localparam int M_ENTRY = 0;
  localparam int M_SEND  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  typedef struct packed {
    logic [3:0] dout;
    logic       cen;
    logic       clr;
    logic [3:0] mn;
    logic [3:0] st;
    logic [3:0] su;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clock = 1'b0;
  logic       Cn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       zero = 1'b0;
  logic [3:0] digit_out;
  logic       count_en;
  logic       timer_clr_n;
  logic [3:0] entry_min;
  logic [3:0] entry_sec_t;
  logic [3:0] entry_sec_u;
  logic       busy;
  logic       done;

  microondas_time_entry dut (
    .clock       (clock),
    .Cn          (Cn),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .zero        (zero),
    .digit_out   (digit_out),
    .count_en    (count_en),
    .timer_clr_n (timer_clr_n),
    .entry_min   (entry_min),
    .entry_sec_t (entry_sec_t),
    .entry_sec_u (entry_sec_u),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Behavioural countdown timer: shifts in digit_out while loading, counts M:SS down.
  logic [3:0] tm_m = 4'd0, tm_t = 4'd0, tm_u = 4'd0;
  logic       tm_zero;
  always @(posedge clock or negedge Cn) begin
    if (!Cn || !timer_clr_n) begin
      tm_m <= 4'd0; tm_t <= 4'd0; tm_u <= 4'd0;
    end else if (!count_en) begin
      tm_m <= tm_t; tm_t <= tm_u; tm_u <= digit_out;
    end else if (tm_u != 4'd0) begin
      tm_u <= tm_u - 4'd1;
    end else if (tm_t != 4'd0) begin
      tm_t <= tm_t - 4'd1; tm_u <= 4'd9;
    end else if (tm_m != 4'd0) begin
      tm_m <= tm_m - 4'd1; tm_t <= 4'd5; tm_u <= 4'd9;
    end
  end
  assign tm_zero = (tm_m == 4'd0) && (tm_t == 4'd0) && (tm_u == 4'd0);

  int    n_cmp = 0;
  int    n_bad = 0;
  obs_t  sb_q[$];
  string tag_q[$];
  string phase = "reset";
  bit    zf_en = 1'b0;
  bit    zf_val = 1'b0;

  // Reference model: buffer held as a 0..999 number, send order as a queue.
  int         m_mode;
  int         m_val;
  int         m_q[$];
  int         m_age;
  logic [3:0] m_dout;
  logic       m_clr;

  function automatic void m_reset();
    m_mode = M_ENTRY; m_val = 0; m_q.delete(); m_age = 0; m_dout = 4'd0; m_clr = 1'b1;
  endfunction

  function automatic void m_step(input logic v, input logic [3:0] c, input logic z);
    bit dig    = v && (c < 4'd10);
    bit start  = v && (c == 4'd10);
    bit cancel = v && (c == 4'd11);
    m_clr = 1'b1;
    if (cancel && (m_mode == M_SEND || m_mode == M_RUN)) begin
      m_val = 0; m_clr = 1'b0; m_mode = M_ENTRY; m_q.delete();
    end else begin
      case (m_mode)
        M_ENTRY: begin
          if (cancel) m_val = 0;
          else if (dig) m_val = (m_val * 10 + int'(c)) % 1000;
          else if (start && m_val != 0) begin
            m_q.delete();
            m_q.push_back(m_val / 100);
            m_q.push_back((m_val / 10) % 10);
            m_q.push_back(m_val % 10);
            m_dout = 4'(m_q.pop_front());
            m_mode = M_SEND;
          end
        end
        M_SEND: begin
          if (m_q.size() == 0) begin m_mode = M_RUN; m_age = 0; end
          else m_dout = 4'(m_q.pop_front());
        end
        M_RUN: begin
          if (z && m_age > 0) m_mode = M_DONE;
          else m_age++;
        end
        default: begin
          if (v && c <= 4'd11) begin
            m_val = dig ? int'(c) : 0;
            m_mode = M_ENTRY;
          end
        end
      endcase
    end
  endfunction

  function automatic obs_t m_exp();
    obs_t e;
    e.dout = m_dout;
    e.cen  = (m_mode == M_RUN);
    e.clr  = m_clr;
    e.mn   = 4'(m_val / 100);
    e.st   = 4'((m_val / 10) % 10);
    e.su   = 4'(m_val % 10);
    e.busy = (m_mode == M_SEND) || (m_mode == M_RUN);
    e.done = (m_mode == M_DONE);
    return e;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.dout = digit_out; o.cen = count_en; o.clr = timer_clr_n;
    o.mn = entry_min; o.st = entry_sec_t; o.su = entry_sec_u;
    o.busy = busy; o.done = done;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("digit_out=%0d count_en=%0b clr_n=%0b buf=%0d:%0d%0d busy=%0b done=%0b",
                     o.dout, o.cen, o.clr, o.mn, o.st, o.su, o.busy, o.done);
  endfunction

  task automatic compare(input obs_t exp, input string tag);
    obs_t got = dut_obs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {%s} expected {%s}", tag, $time, fmt(got), fmt(exp));
    end
  endtask

  // Monitor: every output cycle consumes one queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) compare(sb_q.pop_front(), tag_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [3:0] c);
    logic z;
    @(negedge clock);
    #1;
    z = zf_en ? zf_val : tm_zero;
    key_valid = v; key_code = c; zero = z;
    m_step(v, c, z);
    sb_q.push_back(m_exp());
    tag_q.push_back(phase);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0);
  endtask

  task automatic press(input logic [3:0] c);
    step(1'b1, c);
  endtask

  task automatic check_timer(input logic [3:0] m, input logic [3:0] t, input logic [3:0] u,
                             input string tag);
    n_cmp++;
    if ({tm_m, tm_t, tm_u} !== {m, t, u}) begin
      n_bad++;
      $display("FAIL %s: timer got %0d:%0d%0d expected %0d:%0d%0d", tag, tm_m, tm_t, tm_u, m, t, u);
    end
  endtask

  task automatic run_to_done(input string tag);
    int i = 0;
    while (m_mode != M_DONE && i < 400) begin idle(1); i++; end
    n_cmp++;
    if (m_mode != M_DONE) begin
      n_bad++;
      $display("FAIL %s_timeout: run not finished after %0d cycles, required done", tag, i);
    end
    idle(1);
    check_timer(4'd0, 4'd0, 4'd0, {tag, "_timer_zero"});
  endtask

  task automatic reset_mid(input string tag);
    @(negedge clock);
    #1;
    key_valid = 1'b0; zero = 1'b0; Cn = 1'b0;
    m_reset();
    #1;
    compare(m_exp(), tag);
    repeat (2) @(negedge clock);
    #1;
    Cn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       v;
    logic [3:0] c;
    int         r;
    m_reset();
    repeat (2) @(negedge clock);
    #1;
    compare(m_exp(), "reset_state");
    Cn = 1'b1;

    phase = "run_199";
    press(4'd1); press(4'd9); press(4'd9); press(4'd10);
    idle(4);
    check_timer(4'd1, 4'd9, 4'd9, "timer_load_199");
    run_to_done("run_199");

    phase = "run_030";
    press(4'd3); press(4'd0); press(4'd10);
    idle(4);
    check_timer(4'd0, 4'd3, 4'd0, "timer_load_030");
    run_to_done("run_030");

    phase = "shift_and_zero_start";
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'd11); press(4'd10); idle(3);

    phase = "zero_blanking";
    press(4'd5); press(4'd10); idle(3);
    zf_en = 1'b1;
    zf_val = 1'b1; idle(1);
    zf_val = 1'b0; idle(2);
    zf_val = 1'b1; idle(1);
    zf_val = 1'b0; idle(1);
    press(4'd7); idle(1);
    zf_en = 1'b0;

    phase = "cancel_in_send";
    press(4'd4); press(4'd2); press(4'd10); idle(1);
    press(4'd11); idle(2);

    phase = "cancel_with_zero";
    press(4'd8); press(4'd10); idle(3);
    zf_en = 1'b1; zf_val = 1'b0; idle(2);
    zf_val = 1'b1; press(4'd11); idle(2);
    zf_en = 1'b0;

    phase = "async_reset";
    press(4'd2); press(4'd5); press(4'd10); idle(6);
    reset_mid("async_reset_mid_run");
    press(4'd1); press(4'd9); press(4'd9); press(4'd10);
    idle(4);
    check_timer(4'd1, 4'd9, 4'd9, "timer_reload_after_reset");
    press(4'd11); idle(2);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 99) < 45);
      r = $urandom_range(0, 99);
      if (r < 55)      c = 4'($urandom_range(0, 9));
      else if (r < 72) c = 4'd10;
      else if (r < 78) c = 4'd11;
      else             c = 4'($urandom_range(12, 15));
      zf_en = ($urandom_range(0, 9) < 3);
      zf_val = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) reset_mid("async_reset_random");
      step(v, c);
    end

    zf_en = 1'b0;
    idle(1);
    @(negedge clock);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microondas_time_entry.md
Name: microondas_time_entry

Overview:
Keypad-side time-entry controller. It is the writer feeding the countdown timer's serial digit-load interface. It collects digit key presses into a 3-digit M:ST:SU buffer and, on START, shifts the digits into the timer MSD-first with the load/count line low. It then releases the timer to count and watches the timer's zero flag to report completion. CANCEL aborts at any point by pulsing the timer clear.

Parameters:
NUM_DIGITS, 3, digits in entry buffer (min, sec tens, sec units)
DIGIT_W, 4, BCD digit width

Ports:
clock  in  1  system clock, all state on rising edge
Cn  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit, 10 START, 11 CANCEL, 12-15 ignored
zero  in  1  timer reached 0:00
digit_out  out  4  serial digit to timer data input
count_en  out  1  timer load/count select: 0 = load digit_out this cycle, 1 = count
timer_clr_n  out  1  active-low timer clear
entry_min  out  4  buffer digit 2 (preview display)
entry_sec_t  out  4  buffer digit 1
entry_sec_u  out  4  buffer digit 0
busy  out  1  high in SEND or RUN
done  out  1  high in DONE

Behaviour:
- Reset (Cn=0, async): state ENTRY, buffer 0:00, digit_out=0, count_en=0, timer_clr_n=1, busy=0, done=0, send index=0.
- States: ENTRY, SEND, RUN, DONE. All outputs are registered.
- ENTRY, digit key: shift-left. min<=sec_t, sec_t<=sec_u, sec_u<=key. A 4th or later digit discards the oldest. No range check; sec tens 6-9 are legal.
- ENTRY, START: if the buffer is 0:00, ignore it and stay in ENTRY. Otherwise go to SEND with index=2.
- ENTRY, CANCEL: clear the buffer to 0:00. timer_clr_n stays 1.
- ENTRY, codes 12-15: no effect in any state.
- SEND lasts exactly NUM_DIGITS cycles with count_en=0.
  - digit_out = min, then sec_t, then sec_u, one per cycle.
  - On the cycle after the third digit, go to RUN.
  - The buffer is held unchanged. Digit and START keys are ignored.
- RUN: count_en=1; digit_out holds the last value.
  - zero is blanked on the first RUN cycle. From the second cycle on, zero=1 -> DONE.
- CANCEL in SEND or RUN: timer_clr_n=0 for exactly one cycle. count_en<=0, buffer cleared, next state ENTRY.
- CANCEL and zero in the same cycle: CANCEL wins and the block enters ENTRY, not DONE.
- DONE: done=1, count_en=0, buffer holds the last programmed time.
  - Any valid key (0-11) -> ENTRY with the buffer first cleared to 0:00.
  - A digit key in that same cycle is then shifted in, giving 0:0d.
  - START in DONE does not restart.
- Reset mid-SEND or mid-RUN: immediate return to reset values. No timer_clr_n pulse is generated; the timer shares Cn.
- key_valid held high for multiple cycles counts as one press per cycle. Debounce is upstream.

Decomposition:
- Shared package microondas_pkg holds:
  - KEY_START=4'd10, KEY_CANCEL=4'd11
  - state encoding ST_ENTRY/ST_SEND/ST_RUN/ST_DONE
  - NUM_DIGITS, DIGIT_W
  - BCD zero constant
- One sub-module, microondas_entry_buffer, provides:
  - NUM_DIGITS x DIGIT_W shift register
  - ports: shift, clear, digit in
  - is_zero flag
  - indexed read for SEND
- The FSM and timer-side outputs stay in the top.

Test Plan:
- Keys 1,9,9 then START -> preview shows 1:99. Then 3 cycles of count_en=0 with digit_out 1,9,9. Then count_en=1, busy=1.
- Keys 1,2,3,4 -> buffer 2:34. START with buffer 0:00 (after CANCEL) -> stays in ENTRY, count_en=0 throughout.
- Run 0:05 with zero forced 1 on the first RUN cycle -> no transition. zero=1 on the 4th RUN cycle -> done=1 next cycle, busy=0. Key 7 -> ENTRY, buffer 0:07.
- CANCEL on the 2nd SEND cycle -> timer_clr_n low exactly one cycle, buffer 0:00, ENTRY. CANCEL and zero together in RUN -> ENTRY, done stays 0.
- Cn asserted mid-RUN (asynchronously, between clock edges) -> all outputs at reset values before the next edge. After release, keys 1,9,9 then START -> 1:99 resend works.
- Integration with the timer: program 1:99, wait for zero -> done=1 and timer digits 0:00. Start a second run of 0:30 -> the timer reloads correctly.
